scroll_display: RTL and testbench

//  Consumer of the 1 kHz and scroll toggle clocks from the clock divider. Samples both toggle levels in clk_i.

---
 rtl/scroll_display_if.sv | 25 ++
 rtl/scroll_display.sv | 154 +++++++++++++++
 tb/tb_scroll_display.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/scroll_display_if.sv
// Message write port of scroll_display: valid/ready handshake
// carrying a character index and a character code.
interface scroll_display_if #(
    parameter int AW = 4,
    parameter int CW = 5
);
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/scroll_display.sv
// Scrolling 7-seg message display driven by 1 kHz and scroll toggle levels.
// Define SCROLL_PAUSE_EN to add pause_i, which discards scroll ticks.
module scroll_display #(
    parameter int MSG_LEN = 16,
    parameter int DIGITS  = 4,
    parameter int CHAR_W  = 5
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clk_1k_i,
    input  logic                       clk_scroll_i,
`ifdef SCROLL_PAUSE_EN
    input  logic                       pause_i,
`endif
    scroll_display_if.slave            wr,
    output logic [$clog2(MSG_LEN)-1:0] pos_o,
    output logic [DIGITS-1:0]          an_o,
    output logic [6:0]                 seg_o
);
    localparam int AW  = $clog2(MSG_LEN);
    localparam int AW1 = AW + 1;
    localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CHAR_W-1:0] BLANK = CHAR_W'(5'h1F);

    logic [1:0]        s1_q, s1_d, s2_q, s2_d;
    logic [1:0]        hist_q, hist_d, vld_q, vld_d;
    logic              armed_q, armed_d, run_q, run_d;
    logic              upd_q, upd_d;
    logic [DW-1:0]     digit_q, digit_d;
    logic [AW-1:0]     offset_q, offset_d;
    logic [CHAR_W-1:0] msg_q [MSG_LEN];
    logic [CHAR_W-1:0] msg_d [MSG_LEN];
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [1:0]        tick;
    logic              digit_tick, scroll_tick, scroll_adv;
    logic              wr_fire;
    logic [AW1-1:0]    sum;
    logic [AW-1:0]     idx;
    logic [CHAR_W-1:0] chr;

    function automatic logic [6:0] glyph(input logic [CHAR_W-1:0] c);
        logic [6:0] g;
        g = 7'h7F;
        if (int'(c) < 16) begin
            unique case (c[3:0])
                4'h0: g = 7'h40;
                4'h1: g = 7'h79;
                4'h2: g = 7'h24;
                4'h3: g = 7'h30;
                4'h4: g = 7'h19;
                4'h5: g = 7'h12;
                4'h6: g = 7'h02;
                4'h7: g = 7'h78;
                4'h8: g = 7'h00;
                4'h9: g = 7'h10;
                4'hA: g = 7'h08;
                4'hB: g = 7'h03;
                4'hC: g = 7'h46;
                4'hD: g = 7'h21;
                4'hE: g = 7'h06;
                4'hF: g = 7'h0E;
            endcase
        end
        return g;
    endfunction

    // Ticks only after the synchronizer holds real samples (vld_q[1]).
    assign tick        = armed_q ? (s2_q ^ hist_q) : 2'b00;
    assign digit_tick  = tick[0];
    assign scroll_tick = tick[1];
`ifdef SCROLL_PAUSE_EN
    assign scroll_adv  = scroll_tick & ~pause_i;
`else
    assign scroll_adv  = scroll_tick;
`endif
    assign wr.wr_ready = run_q & ~scroll_adv;
    assign wr_fire     = wr.wr_valid & wr.wr_ready;

    always_comb begin
        s1_d     = {clk_scroll_i, clk_1k_i};
        s2_d     = s1_q;
        hist_d   = s2_q;
        vld_d    = {vld_q[0], 1'b1};
        armed_d  = armed_q | vld_q[1];
        run_d    = 1'b1;
        upd_d    = digit_tick;
        digit_d  = digit_q;
        offset_d = offset_q;
        msg_d    = msg_q;
        an_d     = an_q;
        seg_d    = seg_q;

        if (digit_tick) begin
            if (int'(digit_q) == DIGITS - 1) digit_d = '0;
            else                             digit_d = digit_q + DW'(1);
        end
        if (scroll_adv) begin
            if (int'(offset_q) == MSG_LEN - 1) offset_d = '0;
            else                               offset_d = offset_q + AW'(1);
        end
        if (wr_fire && int'(wr.wr_addr) < MSG_LEN) begin
            msg_d[wr.wr_addr] = wr.wr_data;
        end

        sum = AW1'(offset_q) + AW1'(digit_q);
        if (int'(sum) >= MSG_LEN) sum = sum - AW1'(MSG_LEN);
        idx = sum[AW-1:0];
        chr = msg_q[idx];

        // Refresh only the cycle after the digit advanced.
        if (upd_q) begin
            seg_d = glyph(chr);
            for (int i = 0; i < DIGITS; i++) begin
                an_d[i] = (i != DIGITS - 1 - int'(digit_q));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= '0;
            s2_q     <= '0;
            hist_q   <= '0;
            vld_q    <= '0;
            armed_q  <= 1'b0;
            run_q    <= 1'b0;
            upd_q    <= 1'b0;
            digit_q  <= '0;
            offset_q <= '0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= BLANK;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            hist_q   <= hist_d;
            vld_q    <= vld_d;
            armed_q  <= armed_d;
            run_q    <= run_d;
            upd_q    <= upd_d;
            digit_q  <= digit_d;
            offset_q <= offset_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            msg_q    <= msg_d;
        end
    end

    assign pos_o = offset_q;
    assign an_o  = an_q;
    assign seg_o = seg_q;
endmodule

// File: tb/tb_scroll_display.sv
// Testbench for scroll_display: directed and random toggles/writes
// checked against a message/offset/digit model.
module tb_scroll_display;
    localparam int ML = 16;
    localparam int DG = 4;
    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk;
    logic       rst_n;
    logic       clk_1k;
    logic       clk_scroll;
    logic       pause;
    logic [3:0] pos;
    logic [3:0] an;
    logic [6:0] seg;

    scroll_display_if #(.AW(4), .CW(5)) wr_if ();

    scroll_display #(.MSG_LEN(ML), .DIGITS(DG), .CHAR_W(5)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clk_1k_i     (clk_1k),
        .clk_scroll_i (clk_scroll),
`ifdef SCROLL_PAUSE_EN
        .pause_i      (pause),
`endif
        .wr           (wr_if),
        .pos_o        (pos),
        .an_o         (an),
        .seg_o        (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model
    int m_msg [ML];
    int m_off;
    int m_dig;
    int m_an;
    int m_seg;
    bit m_paused;

    task automatic chk(string tag, int unsigned obs, int unsigned exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        foreach (m_msg[i]) m_msg[i] = 31;
        m_off = 0;
        m_dig = 0;
        m_an  = 'hF;
        m_seg = 'h7F;
    endtask

    function automatic int shown_seg();
        int c;
        c = m_msg[(m_off + m_dig) % ML];
        return (c >= 16) ? 'h7F : int'(GLYPH[c]);
    endfunction

    task automatic refresh();
        m_an  = (~(1 << (DG - 1 - m_dig))) & 'hF;
        m_seg = shown_seg();
    endtask

    // Called just after a posedge; flips levels and follows the tick through.
    task automatic toggle(bit k, bit s);
        bit adv;
        adv = s && !m_paused;
        if (k) clk_1k = ~clk_1k;
        if (s) clk_scroll = ~clk_scroll;
        cyc(2);
        chk("ready_tick", wr_if.wr_ready, adv ? 0 : 1);
        if (adv) m_off = (m_off + 1) % ML;
        if (k) begin
            m_dig = (m_dig + 1) % DG;
            refresh();
        end
        cyc(2);
        chk("pos", pos, m_off);
        chk("an", an, m_an);
        chk("seg", seg, m_seg);
    endtask

    task automatic write(int a, int d);
        bit acc;
        acc = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 4'(a);
        wr_if.wr_data  = 5'(d);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = wr_if.wr_ready;
            @(posedge clk);
        end
        #1;
        wr_if.wr_valid = 1'b0;
        chk("wr_accept", acc, 1);
        if (acc && a < ML) m_msg[a] = d;
    endtask

    task automatic reset_checks();
        chk("rst_an", an, 'hF);
        chk("rst_seg", seg, 'h7F);
        chk("rst_pos", pos, 0);
        chk("rst_ready", wr_if.wr_ready, 0);
    endtask

    initial begin
        int a, d, op;
        clk_1k         = 1'b1;
        clk_scroll     = 1'b0;
        pause          = 1'b0;
        m_paused       = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr  = '0;
        wr_if.wr_data  = '0;
        rst_n          = 1'b0;
        model_reset();
        cyc(3);
        reset_checks();

        // T1: level already high at release must not tick
        rst_n = 1'b1;
        cyc(10);
        chk("t1_an", an, 'hF);
        chk("t1_seg", seg, 'h7F);

        // T2: digits 0..3 show 1..4
        for (int i = 0; i < 4; i++) write(i, i + 1);
        for (int i = 0; i < 4; i++) toggle(1, 0);

        // T3: wrap of offset and of display index
        write(15, 'hA);
        write(1, 'hC);
        for (int i = 0; i < 15; i++) toggle(0, 1);
        for (int i = 0; i < 4; i++) toggle(1, 0);
        toggle(0, 1);

        // T4: write held across a scroll tick
        clk_scroll = ~clk_scroll;
        cyc(2);
        a = (m_off + 1) % ML;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = 4'(a);
        wr_if.wr_data  = 5'h0E;
        @(negedge clk);
        chk("t4_ready_lo", wr_if.wr_ready, 0);
        @(posedge clk);
        #1;
        m_off = (m_off + 1) % ML;
        chk("t4_pos", pos, m_off);
        @(negedge clk);
        chk("t4_ready_hi", wr_if.wr_ready, 1);
        @(posedge clk);
        #1;
        wr_if.wr_valid = 1'b0;
        m_msg[a] = 'hE;
        for (int i = 0; i < DG; i++) toggle(1, 0);

        // T5: simultaneous ticks
        for (int i = 0; i < 3; i++) toggle(1, 1);

`ifdef SCROLL_PAUSE_EN
        // T6: paused scroll ticks are dropped
        pause = 1'b1;
        m_paused = 1'b1;
        for (int i = 0; i < 3; i++) toggle(0, 1);
        toggle(1, 1);
        pause = 1'b0;
        m_paused = 1'b0;
        toggle(0, 1);
`endif

        // Random mix
        for (int n = 0; n < 60; n++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                a = int'($urandom_range(0, ML - 1));
                d = int'($urandom_range(0, 31));
                write(a, d);
            end else begin
                toggle(op != 2, op != 1);
            end
        end

        // Reset mid-operation
        rst_n = 1'b0;
        #1;
        reset_checks();
        model_reset();
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        toggle(1, 0);
        toggle(0, 1);
        write(2, 5);
        toggle(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
